oloca_share_arbiter: RTL

- Shares one OLOCA approximate adder datapath among NREQ requesters.
- Each request carries an exact/approximate mode bit.
- Round-robin arbitration, valid/ready handshakes on every requester port and on a single registered response port.
- Sits between accelerator lanes issuing additions and the single adder instance; the adder is instantiated inside this block.

---
 rtl/oloca_pkg.sv | 37 +++
 rtl/oloca_datapath.sv | 31 +++
 rtl/oloca_share_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/oloca_pkg.sv
// Shared definitions for the OLOCA shared-adder arbiter: mode encoding,
// default sizes and a width-generic reference for the approximate sum.
package oloca_pkg;

    typedef enum logic {
        MODE_APPROX = 1'b0,
        MODE_EXACT  = 1'b1
    } mode_e;

    localparam int DEF_N    = 8;
    localparam int DEF_LPL  = 4;
    localparam int DEF_NREQ = 4;
    localparam int DEF_CNTW = 16;

    localparam int MAXW = 64;

    // Operands are zero-extended to MAXW; n and lpl select the real geometry.
    function automatic logic [MAXW:0] oloca_approx_sum(
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b,
        input int unsigned     n,
        input int unsigned     lpl
    );
        logic [MAXW-1:0] hi_mask;
        logic [MAXW-1:0] lo_mask;
        logic [MAXW-1:0] or_mask;
        logic [MAXW-1:0] low;
        logic [MAXW:0]   hi_sum;
        hi_mask = (64'd1 << (n - lpl)) - 64'd1;
        lo_mask = (64'd1 << lpl) - 64'd1;
        or_mask = 64'd3 << (lpl - 2);
        hi_sum  = {1'b0, (a >> lpl) & hi_mask} + {1'b0, (b >> lpl) & hi_mask};
        low     = (lo_mask & ~or_mask) | ((a | b) & or_mask);
        return (hi_sum << lpl) | {1'b0, low};
    endfunction

endpackage

// File: rtl/oloca_datapath.sv
// Single shared adder: precise N-bit add or OLOCA approximate add
// (precise upper part, OR on the top two lower bits, constant ones below).
module oloca_datapath
    import oloca_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LPL = DEF_LPL
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         exact,
    output logic [N:0]   result
);

    logic [N:0]     exact_sum;
    logic [N-LPL:0] hi_sum;
    logic [LPL-1:0] lo_bits;

    always_comb begin
        exact_sum = {1'b0, a} + {1'b0, b};
        hi_sum    = {1'b0, a[N-1:LPL]} + {1'b0, b[N-1:LPL]};
        lo_bits   = '1;
        lo_bits[LPL-1 -: 2] = a[LPL-1 -: 2] | b[LPL-1 -: 2];
        if (mode_e'(exact) == MODE_EXACT) begin
            result = exact_sum;
        end else begin
            result = {hi_sum, lo_bits};
        end
    end

endmodule

// File: rtl/oloca_share_arbiter.sv
// Round-robin arbiter sharing one OLOCA adder among NREQ requesters,
// with a single registered valid/ready response slot.
module oloca_share_arbiter
    import oloca_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int LPL  = DEF_LPL,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = DEF_CNTW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_exact,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N:0]        rsp_result,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_exact,
    output logic [CNTW-1:0]   approx_cnt
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [N:0]      rsp_result_q, rsp_result_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_exact_q, rsp_exact_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            slot_free;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand_idx;
    int              cand;
    logic            accept;
    logic [N-1:0]    a_sel;
    logic [N-1:0]    b_sel;
    logic            exact_sel;
    logic [N:0]      dp_result;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        slot_free = !rsp_valid_q || rsp_ready;
        accept    = rst_n && slot_free && gnt_found;
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
        a_sel     = req_a[int'(gnt_idx)*N +: N];
        b_sel     = req_b[int'(gnt_idx)*N +: N];
        exact_sel = req_exact[gnt_idx];
    end

    oloca_datapath #(
        .N   (N),
        .LPL (LPL)
    ) u_datapath (
        .a      (a_sel),
        .b      (b_sel),
        .exact  (exact_sel),
        .result (dp_result)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_exact_d  = rsp_exact_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        if (slot_free) begin
            rsp_valid_d = accept;
        end
        if (accept) begin
            rsp_result_d = dp_result;
            rsp_id_d     = gnt_idx;
            rsp_exact_d  = exact_sel;
            if (int'(gnt_idx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
            if (mode_e'(exact_sel) == MODE_APPROX && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            rsp_exact_q  <= 1'b0;
            ptr_q        <= '0;
            cnt_q        <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_exact_q  <= rsp_exact_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_exact  = rsp_exact_q;
    assign approx_cnt = cnt_q;

endmodule
